// File: rtl/dmem_arbiter.sv
// ============================================================================
// Module  : dmem_arbiter
// Purpose : Round-robin two-core arbiter sequencing single accesses to data_mem.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module dmem_arbiter #(
  parameter int n         = 32,
  parameter int dmem_size = 6,
  parameter int MEM_LAT   = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 c0_req,
  input  logic                 c0_we,
  input  logic [dmem_size-1:0] c0_addr,
  input  logic [n-1:0]         c0_wdata,
  output logic                 c0_ack,
  output logic [n-1:0]         c0_rdata,
  input  logic                 c1_req,
  input  logic                 c1_we,
  input  logic [dmem_size-1:0] c1_addr,
  input  logic [n-1:0]         c1_wdata,
  output logic                 c1_ack,
  output logic [n-1:0]         c1_rdata,
  output logic [dmem_size-1:0] dmem_address,
  output logic [n-1:0]         dmem_wdata,
  output logic                 load_control,
  output logic                 store_control,
  input  logic [n-1:0]         dmem_rdata,
  output logic                 busy,
  output logic                 last_grant
);

  localparam int CNT_W = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  state_t               state_q, state_d;
  logic                 owner_q, owner_d;
  logic                 we_q, we_d;
  logic                 last_grant_q, last_grant_d;
  logic [dmem_size-1:0] addr_q, addr_d;
  logic [n-1:0]         wdata_q, wdata_d;
  logic [n-1:0]         c0_rdata_q, c0_rdata_d;
  logic [n-1:0]         c1_rdata_q, c1_rdata_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 grant_idx;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      owner_q      <= 1'b0;
      we_q         <= 1'b0;
      last_grant_q <= 1'b1;
      addr_q       <= '0;
      wdata_q      <= '0;
      c0_rdata_q   <= '0;
      c1_rdata_q   <= '0;
      cnt_q        <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      we_q         <= we_d;
      last_grant_q <= last_grant_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      c0_rdata_q   <= c0_rdata_d;
      c1_rdata_q   <= c1_rdata_d;
      cnt_q        <= cnt_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    we_d         = we_q;
    last_grant_d = last_grant_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    c0_rdata_d   = c0_rdata_q;
    c1_rdata_d   = c1_rdata_q;
    cnt_d        = cnt_q;
    // On a tie the core that did not win last time is chosen.
    grant_idx    = (c0_req && c1_req) ? ~last_grant_q : c1_req;

    case (state_q)
      IDLE: begin
        if (c0_req || c1_req) begin
          owner_d      = grant_idx;
          last_grant_d = grant_idx;
          we_d         = grant_idx ? c1_we    : c0_we;
          addr_d       = grant_idx ? c1_addr  : c0_addr;
          wdata_d      = grant_idx ? c1_wdata : c0_wdata;
          state_d      = ISSUE;
        end
      end
      ISSUE: begin
        cnt_d   = CNT_W'(MEM_LAT);
        state_d = WAIT;
      end
      WAIT: begin
        if (cnt_q <= CNT_W'(1)) begin
          if (!we_q) begin
            if (owner_q) c1_rdata_d = dmem_rdata;
            else         c0_rdata_d = dmem_rdata;
          end
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Strobes and acks decode from the state register so reset kills them at once.
  assign load_control  = (state_q == ISSUE) && !we_q;
  assign store_control = (state_q == ISSUE) &&  we_q;
  assign c0_ack        = (state_q == RESP)  && !owner_q;
  assign c1_ack        = (state_q == RESP)  &&  owner_q;
  assign busy          = (state_q != IDLE);
  assign last_grant    = last_grant_q;
  assign dmem_address  = addr_q;
  assign dmem_wdata    = wdata_q;
  assign c0_rdata      = c0_rdata_q;
  assign c1_rdata      = c1_rdata_q;

endmodule

`default_nettype wire
